// File: rtl/hex_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : hex_result_display
//  Description : Display stage of the hex calculator. Holds the last 32-bit
//                result and scans it as 8 hex digits over an 8-digit
//                multiplexed seven-segment display. Enables and segments are
//                active-low. Leading zeros can be blanked. A dash is shown
//                on every digit until a result has been captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_result_display #(
    parameter int SCAN_DIV = 20000,  // clk cycles each digit stays lit
    parameter bit BLANK_LZ = 1'b1    // 1: blank leading zero digits
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        result_valid,
    input  logic        clear,
    input  logic [31:0] cal_result,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    localparam int             CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Segment vectors are ordered {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] SEG_OFF  = 7'b111_1111;
    localparam logic [6:0] SEG_DASH = 7'b111_1110;
    localparam logic [7:0] EN_OFF   = 8'hFF;

    // Hex nibble to active-low segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b000_0001;
            4'h1:    s = 7'b100_1111;
            4'h2:    s = 7'b001_0010;
            4'h3:    s = 7'b000_0110;
            4'h4:    s = 7'b100_1100;
            4'h5:    s = 7'b010_0100;
            4'h6:    s = 7'b010_0000;
            4'h7:    s = 7'b000_1111;
            4'h8:    s = 7'b000_0000;
            4'h9:    s = 7'b000_0100;
            4'hA:    s = 7'b000_1000;
            4'hB:    s = 7'b110_0000;
            4'hC:    s = 7'b011_0001;
            4'hD:    s = 7'b100_0010;
            4'hE:    s = 7'b011_0000;
            default: s = 7'b011_1000;
        endcase
        return s;
    endfunction

    logic [31:0]      disp_q,     disp_d;
    logic             has_q,      has_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       digit_q,    digit_d;
    logic [7:0]       led_en_q,   led_en_d;
    logic [6:0]       seg_q,      seg_d;

    logic             scan_last;
    logic [4:0]       nib_base;
    logic [3:0]       nibble;
    logic [31:0]      upper_bits;
    logic             blank_slot;

    // Result capture: clear has priority over a simultaneous valid.
    always_comb begin
        disp_d = disp_q;
        has_d  = has_q;
        if (clear) begin
            disp_d = '0;
            has_d  = 1'b0;
        end else if (result_valid) begin
            disp_d = cal_result;
            has_d  = 1'b1;
        end
    end

    // Scan timing: advance to the next digit every SCAN_DIV cycles, 7 wraps to 0.
    always_comb begin
        scan_last  = (scan_cnt_q == CNT_LAST);
        scan_cnt_d = scan_last ? '0 : (scan_cnt_q + CNT_ONE);
        digit_d    = scan_last ? (digit_q + 3'd1) : digit_q;
    end

    // Output decode for the current slot; registered below so outputs lag state by one clk.
    always_comb begin
        nib_base   = {digit_q, 2'b00};
        nibble     = disp_q[nib_base +: 4];
        upper_bits = disp_q >> nib_base;
        blank_slot = BLANK_LZ && has_q && (digit_q != 3'd0) && (upper_bits == 32'd0);

        led_en_d = ~(8'b0000_0001 << digit_q);
        seg_d    = has_q ? seg_decode(nibble) : SEG_DASH;
        if (blank_slot) begin
            led_en_d = EN_OFF;
            seg_d    = SEG_OFF;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q     <= '0;
            has_q      <= 1'b0;
            scan_cnt_q <= '0;
            digit_q    <= 3'd0;
            led_en_q   <= EN_OFF;
            seg_q      <= SEG_OFF;
        end else begin
            disp_q     <= disp_d;
            has_q      <= has_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            led_en_q   <= led_en_d;
            seg_q      <= seg_d;
        end
    end

    assign led_en = led_en_q;
    assign led_ca = seg_q[6];
    assign led_cb = seg_q[5];
    assign led_cc = seg_q[4];
    assign led_cd = seg_q[3];
    assign led_ce = seg_q[2];
    assign led_cf = seg_q[1];
    assign led_cg = seg_q[0];
    // The decimal point is never used by the calculator.
    assign led_dp = 1'b1;

endmodule
`default_nettype wire
